// File: rtl/alu_pkg.sv
// Shared widths, opcodes, FSM encoding and frame layout for the serial ALU front end.
package alu_pkg;

    localparam int OPW  = 3;
    localparam int SELW = 2;
    localparam int RESW = 2 * OPW;
    localparam int FRMW = SELW + 2 * OPW;
    localparam int CNTW = $clog2(FRMW);

    localparam logic [SELW-1:0] OP_ADD = 2'b00;
    localparam logic [SELW-1:0] OP_SUB = 2'b01;
    localparam logic [SELW-1:0] OP_MUL = 2'b10;
    localparam logic [SELW-1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [CNTW-1:0] FRM_LAST = CNTW'(FRMW - 1);
    localparam logic [CNTW-1:0] RES_LAST = CNTW'(RESW - 1);

    typedef struct packed {
        logic [SELW-1:0] sel;
        logic [OPW-1:0]  a;
        logic [OPW-1:0]  b;
    } frame_t;

    function automatic logic is_div_zero(input frame_t f);
        return (f.sel == OP_DIV) && (f.b == '0);
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Generic left-shifting register with parallel load; serves as both the command SIPO
// and the result PISO (MSB leaves first, zeros fill from the right).
module ser_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             shift_in,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_en) begin
            data <= {data[WIDTH-2:0], shift_in};
        end
    end

endmodule

// File: rtl/alu_serial_frontend.sv
// Serial command/response front end for the external 3-bit ALU: gathers an 8-bit frame,
// presents it to the ALU for one cycle, then streams the 6-bit result out under valid/ready.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for / receiving frame bits (bit_cnt = bits so far)
//  EXEC    | frame fields drive the ALU; result captured at cycle end
//  SEND    | result streamed MSB first, one bit per handshake
module alu_serial_frontend
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            sdi,
    input  logic            sdi_valid,
    output logic [OPW-1:0]  alu_a,
    output logic [OPW-1:0]  alu_b,
    output logic [SELW-1:0] alu_sel,
    input  logic [RESW-1:0] alu_result,
    output logic            sdo,
    output logic            sdo_valid,
    input  logic            sdo_ready,
    output logic            busy,
    output logic            dz,
    output logic            ovr
);

    logic [1:0]      state;
    logic [CNTW-1:0] bit_cnt;
    logic [FRMW-1:0] frame_q;
    logic [RESW-1:0] out_q;
    frame_t          frame_f;
    logic            recv_acc;
    logic            send_acc;
    logic            exec_cyc;

    assign recv_acc = (state == ST_IDLE) && sdi_valid;
    assign send_acc = (state == ST_SEND) && sdo_ready;
    assign exec_cyc = (state == ST_EXEC);

    ser_shift_reg #(.WIDTH(FRMW)) u_frame_sipo (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (recv_acc),
        .shift_in  (sdi),
        .data      (frame_q)
    );

    ser_shift_reg #(.WIDTH(RESW)) u_result_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (exec_cyc),
        .load_data (alu_result),
        .shift_en  (send_acc),
        .shift_in  (1'b0),
        .data      (out_q)
    );

    assign frame_f = frame_t'(frame_q);
    assign alu_a   = frame_f.a;
    assign alu_b   = frame_f.b;
    assign alu_sel = frame_f.sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            dz      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sdi_valid) begin
                        if (bit_cnt == FRM_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_EXEC;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    dz      <= is_div_zero(frame_f);
                    bit_cnt <= '0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (sdo_ready) begin
                        if (bit_cnt == RES_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // sdo is gated so the drained result register never leaks onto the pin outside SEND
    assign sdo_valid = (state == ST_SEND);
    assign sdo       = sdo_valid & out_q[RESW-1];
    assign busy      = (state != ST_IDLE) || (bit_cnt != '0);
    assign ovr       = sdi_valid && (state != ST_IDLE);

endmodule
